launch_queue: RTL
=================

Name: launch_queue

Overview:
Host-facing kernel launch sequencer that sits directly upstream of the block dispatcher. It buffers host launch requests in a small FIFO, each request being a thread count. For each request in order it parks the dispatcher in reset, presents the thread count, and holds start until the dispatcher reports done. It then retires the launch with a cycle count and a status flag.

Parameters:
QUEUE_DEPTH, 4, FIFO entries of pending launches (power of two, >=2)
CLEAR_CYCLES, 2, cycles disp_reset is held before each launch (>=1)
TIMEOUT_CYCLES, 0, RUN-state watchdog limit; 0 disables the watchdog
CYCLE_W, 16, width of the per-kernel cycle counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
host_valid  in  1  host offers a launch request
host_ready  out  1  queue can accept; a push happens when host_valid && host_ready at a clk edge
host_thread_count  in  8  thread count of the offered launch
disp_reset  out  1  active-high synchronous reset to the dispatcher
disp_start  out  1  start level to the dispatcher
disp_thread_count  out  8  thread count presented to the dispatcher (head entry)
disp_done  in  1  dispatcher done level
kernel_done  out  1  one-cycle pulse when a launch retires
kernel_error  out  1  valid with kernel_done; 1 = watchdog abort
kernel_cycles  out  CYCLE_W  RUN-state cycles of the last retired launch, saturating
queue_count  out  clog2(QUEUE_DEPTH)+1  entries held, including the in-flight head
busy  out  1  state != IDLE

Behaviour:
- Reset (reset low, asynchronous) forces the following; all take effect immediately:
  - state=IDLE, FIFO empty.
  - disp_reset=1, disp_start=0, disp_thread_count=0.
  - kernel_done=0, kernel_error=0, kernel_cycles=0, queue_count=0, busy=0, host_ready=1.
- FIFO:
  - Circular buffer with read/write pointers and a count.
  - host_ready = (count < QUEUE_DEPTH), decoded from registered count.
  - Push and pop in the same cycle leave count unchanged. A push into a full queue cannot happen because host_ready is 0.
- disp_thread_count is the head entry, driven while state is CLEAR or RUN; otherwise 0.
- disp_reset=1 in every state except RUN. disp_start=1 only in RUN.
- State machine:
  - IDLE: if count>0, go to CLEAR with clear counter=0.
    - Exception: if the head thread count is 0, go straight to RETIRE with kernel_cycles=0, error=0. A zero-thread launch never starts the dispatcher.
  - CLEAR: clear counter increments each cycle. After CLEAR_CYCLES cycles, go to RUN and zero the cycle counter.
  - RUN: the cycle counter increments each cycle and saturates at all-ones.
    - If disp_done is sampled 1, go to RETIRE with error=0.
    - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1, go to RETIRE with error=1.
    - disp_done has priority over timeout in the same cycle.
  - RETIRE (1 cycle):
    - kernel_done=1. kernel_error and kernel_cycles are updated and held until the next retire.
    - Pop the head.
    - Next state is CLEAR if count after pop and push is >0 (same zero-count exception as IDLE), else IDLE.
- Latency: push into an empty idle queue gives disp_start high CLEAR_CYCLES+1 cycles after the push edge. disp_done high gives kernel_done exactly 1 cycle later.
- disp_done outside RUN is ignored. The dispatcher's done level persists only until its reset, which CLEAR/RETIRE assert.
- Asynchronous reset mid-RUN discards all queued entries. disp_reset reasserts immediately and no kernel_done is produced.
- Width rules: queue_count is 1 bit wider than the pointer width. kernel_cycles does not wrap.

Decomposition:
- Shared package: state enum (IDLE, CLEAR, RUN, RETIRE) and the launch entry typedef (8-bit thread count).
- Natural sub-module: launch_fifo, a parametric sync FIFO with count, async active-low reset, push/pop and full/empty. The sequencer FSM stays in launch_queue.

Test Plan:
- Push 10 into an empty queue (CLEAR_CYCLES=2). Expected: disp_reset high 2 cycles, then disp_start=1 with disp_thread_count=10. Drive disp_done after 7 RUN cycles. Expected: kernel_done pulse next cycle, kernel_cycles=7, error=0, queue_count 1->0, disp_reset=1.
- Push 4 launches (5, 8, 1, 3) back-to-back. Expected: 4th accepted, host_ready=0 with count=4. Launches run in order with 5, 8, 1, 3 on disp_thread_count, and exactly 4 kernel_done pulses.
- Push 0. Expected: disp_start never asserts; kernel_done after the RETIRE cycle with kernel_cycles=0, error=0.
- TIMEOUT_CYCLES=20, disp_done held 0. Expected: kernel_done with kernel_error=1 and kernel_cycles=20; the next queued launch proceeds through CLEAR.
- Full queue during RETIRE plus simultaneous host push. Expected: host_ready was 0, so no push; host_ready returns 1 the cycle after the pop. Next, count=3 with a push in the RETIRE cycle. Expected: count stays 3.
- Assert reset low mid-RUN with 3 entries. Expected: immediately disp_start=0, disp_reset=1, queue_count=0, busy=0, and no kernel_done pulse.

Source files
------------

// File: rtl/launch_queue_pkg.sv
// Shared types for the kernel launch sequencer: FSM states and the queued launch entry.
package launch_queue_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, RETIRE} state_t;

  typedef struct packed {
    logic [7:0] thread_count;
  } launch_t;

endpackage

// File: rtl/launch_fifo.sv
// Circular launch FIFO with occupancy count; also exposes the entry behind the head so the
// sequencer can look ahead while it retires the current launch.
module launch_fifo
  import launch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     gclk,
  input  logic                     grst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               head,
  output logic [7:0]               second,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  launch_t         mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr, rd_nxt;
  logic            do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_nxt  = rd_ptr + 1'b1;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_nxt;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; entries are only read while count says they are valid.
  always_ff @(posedge gclk) begin
    if (do_push) mem[wr_ptr] <= launch_t'(din);
  end

  assign head   = mem[rd_ptr].thread_count;
  assign second = mem[rd_nxt].thread_count;
  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);

endmodule

// File: rtl/launch_queue.sv
// Kernel launch sequencer: queues host launches and walks each one through
// dispatcher reset, run and retire, reporting cycle count and watchdog status.
module launch_queue
  import launch_queue_pkg::*;
#(
  parameter int QUEUE_DEPTH    = 4,
  parameter int CLEAR_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CYCLE_W        = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           host_valid,
  output logic                           host_ready,
  input  logic [7:0]                     host_thread_count,
  output logic                           disp_reset,
  output logic                           disp_start,
  output logic [7:0]                     disp_thread_count,
  input  logic                           disp_done,
  output logic                           kernel_done,
  output logic                           kernel_error,
  output logic [CYCLE_W-1:0]             kernel_cycles,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
  output logic                           busy
);
  localparam int CW    = $clog2(QUEUE_DEPTH) + 1;
  localparam int CLR_W = $clog2(CLEAR_CYCLES + 1);

  state_t               state, state_nxt;
  logic [CLR_W-1:0]     clr_cnt, clr_nxt;
  logic [CYCLE_W-1:0]   cyc_cnt, cyc_nxt, cyc_inc, ret_cycles, cycles_q;
  logic                 ret_load, ret_err, error_q;
  logic                 push, pop, full, empty, timeout_hit, more;
  logic [7:0]           head, second, next_head;
  logic [CW-1:0]        count;

  assign push = host_valid && !full;
  assign pop  = (state == RETIRE);

  launch_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
    .gclk   (clk),
    .grst_n (reset),
    .push   (push),
    .pop    (pop),
    .din    (host_thread_count),
    .head   (head),
    .second (second),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  assign cyc_inc     = (&cyc_cnt) ? cyc_cnt : cyc_cnt + 1'b1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cyc_cnt == CYCLE_W'(TIMEOUT_CYCLES - 1));
  // Occupancy and head as they will be once the retiring entry pops and any push lands.
  assign more        = (count > CW'(1)) || push;
  assign next_head   = (count > CW'(1)) ? second : host_thread_count;

  always_comb begin
    state_nxt  = state;
    clr_nxt    = clr_cnt;
    cyc_nxt    = cyc_cnt;
    ret_load   = 1'b0;
    ret_err    = 1'b0;
    ret_cycles = '0;
    case (state)
      IDLE: begin
        if (!empty) begin
          if (head == 8'd0) begin
            state_nxt = RETIRE;
            ret_load  = 1'b1;
          end else begin
            state_nxt = CLEAR;
            clr_nxt   = '0;
          end
        end
      end
      CLEAR: begin
        clr_nxt = clr_cnt + 1'b1;
        if (clr_cnt == CLR_W'(CLEAR_CYCLES - 1)) begin
          state_nxt = RUN;
          cyc_nxt   = '0;
        end
      end
      RUN: begin
        cyc_nxt = cyc_inc;
        if (disp_done || timeout_hit) begin
          state_nxt  = RETIRE;
          ret_load   = 1'b1;
          ret_err    = !disp_done;
          ret_cycles = cyc_inc;
        end
      end
      RETIRE: begin
        if (!more) begin
          state_nxt = IDLE;
        end else if (next_head == 8'd0) begin
          state_nxt = RETIRE;
          ret_load  = 1'b1;
        end else begin
          state_nxt = CLEAR;
          clr_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      clr_cnt  <= '0;
      cyc_cnt  <= '0;
      cycles_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_nxt;
      cyc_cnt <= cyc_nxt;
      if (ret_load) begin
        cycles_q <= ret_cycles;
        error_q  <= ret_err;
      end
    end
  end

  assign host_ready        = !full;
  assign disp_reset        = (state != RUN);
  assign disp_start        = (state == RUN);
  assign disp_thread_count = (state == CLEAR || state == RUN) ? head : 8'd0;
  assign kernel_done       = (state == RETIRE);
  assign kernel_error      = error_q;
  assign kernel_cycles     = cycles_q;
  assign queue_count       = count;
  assign busy              = (state != IDLE);

endmodule
